dpi_call_arbiter: RTL
=====================

// Module: dpi_call_arbiter
// PURPOSE
//  Shares one DPI call channel among NREQ requesters (sc_top, childmod, top-level
//  sequencer) using round-robin arbitration with a valid/ready handshake.
//  Includes a run-length cycle counter that closes arbitration after RUN_CYCLES
//  clocks and flags completion to the simulation top.
//  Sits between the requesting blocks and the sample_dpi/sample2 call shim.
// PARAMETERS
//  NREQ        3    number of requesters (2..8)
//  DW          32   payload width passed to the DPI call
//  RUN_CYCLES  20   clocks after reset release before arbitration closes (>=1)
// PORTS
//  clk        in   1          system clock; all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  req        in   NREQ       per-requester call request; held until its ack
//  req_data   in   NREQ*DW    payload; slice i = req_data[i*DW +: DW]; stable while req[i]
//  req_ack    out  NREQ       one-cycle pulse to requester i on call acceptance
//  call_valid out  1          call channel valid
//  call_id    out  3          index of granted requester
//  call_data  out  DW         payload of granted requester
//  call_ready in   1          shim accepts call when call_valid && call_ready
//  cycle_cnt  out  16         clocks since reset release; saturates at RUN_CYCLES
//  run_done   out  1          high once cycle_cnt == RUN_CYCLES and no call in flight
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, call_valid=0, call_id=0, call_data=0,
//   req_ack=0, cycle_cnt=0, run_done=0, rr pointer=0 (requester 0 highest).
//   rst mid-call drops call_valid the next cycle; the pending call is discarded, no ack.
//  Counter: +1 per clock while cycle_cnt < RUN_CYCLES; holds at RUN_CYCLES.
//   closed = (cycle_cnt == RUN_CYCLES).
//  FSM:
//   IDLE:  if !closed && |req: grant first set req[i] searching from rr ptr upward
//          with wrap; register call_id=i, call_data=slice i, call_valid=1 -> CALL.
//          if closed -> DONE. Grant latency: req to call_valid = 1 clock.
//   CALL:  call_valid, call_id, call_data held stable until call_valid&&call_ready.
//          On handshake: req_ack[call_id]=1 next cycle (single pulse),
//          call_valid=0, rr ptr=(call_id+1) mod NREQ -> IDLE (or DONE if closed).
//          Closing while in CALL does not abort the call; it completes first.
//   DONE:  call_valid=0, run_done=1; new reqs ignored, never acked; exit only by rst.
//  Throughput: at most one call per 2 clocks (grant, then IDLE re-arbitration).
//  Requester dropping req before ack while granted is a protocol error; the
//   captured call still completes and is acked.
//  call_ready while call_valid=0 is ignored. Simultaneous closed and handshake:
//   ack is issued, then DONE.
//  call_id zero-extended to 3 bits; unused high bits 0.
// TESTING
//  1 rst held 3 clks, release, no req -> cycle_cnt counts 1..20, holds 20; run_done=1 at cnt 20.
//  2 req=3'b001, data0=0xA5, call_ready=1 -> call_valid 1 clk later, call_id=0,
//    call_data=0xA5; req_ack=3'b001 pulse for exactly 1 clk.
//  3 req=3'b111 held, call_ready=1 -> grant order 0,1,2,0,...; each ack single pulse.
//  4 req=3'b010, call_ready=0 for 5 clks then 1 -> call_valid/id/data stable all 5 clks,
//    ack only after ready.
//  5 call in flight at cycle 19, ready at cycle 22 -> call acked, then DONE;
//    later req=3'b100 never acked, call_valid stays 0.
//  6 rst asserted during CALL -> call_valid=0 next clk, no req_ack, cycle_cnt=0.

Source files
------------

// File: rtl/dpi_call_arbiter.sv
// Round-robin arbiter sharing one DPI call channel among NREQ requesters, with a
// run-length counter that closes arbitration after RUN_CYCLES clocks.
module dpi_call_arbiter #(
  parameter int NREQ       = 3,
  parameter int DW         = 32,
  parameter int RUN_CYCLES = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ack,
  output logic               call_valid,
  output logic [2:0]         call_id,
  output logic [DW-1:0]      call_data,
  input  logic               call_ready,
  output logic [15:0]        cycle_cnt,
  output logic               run_done,
  output logic [1:0]         state_dbg
);

  // Handshake: a call transfers on a rising clk edge where call_valid && call_ready;
  // call_valid/id/data are held stable from grant until that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] RUN_C = 16'(RUN_CYCLES);
  localparam logic [2:0]  LAST  = 3'(NREQ - 1);

  state_t          state_q;
  logic            call_valid_q;
  logic [2:0]      call_id_q;
  logic [DW-1:0]   call_data_q;
  logic [NREQ-1:0] req_ack_q;
  logic [15:0]     cnt_q, cnt_d;
  logic            run_done_q;
  logic [2:0]      rr_ptr_q;

  logic            closed_q, closed_d;
  logic [7:0]      req8;
  logic [DW-1:0]   data_arr [8];
  logic            grant_hit;
  logic [2:0]      grant_idx;
  logic [2:0]      scan_idx;
  logic [3:0]      scan_sum;
  logic [7:0]      ack8;
  logic [2:0]      rr_next;

  assign cnt_d    = (cnt_q < RUN_C) ? cnt_q + 16'd1 : cnt_q;
  assign closed_q = (cnt_q == RUN_C);
  assign closed_d = (cnt_d == RUN_C);
  assign ack8     = 8'd1 << call_id_q;
  assign rr_next  = (call_id_q == LAST) ? 3'd0 : call_id_q + 3'd1;

  // A requester still sees its ack during the cycle after the handshake, so its
  // req is masked then to avoid re-granting a call that was just completed.
  always_comb begin
    req8      = '0;
    req8[NREQ-1:0] = req & ~req_ack_q;
    grant_hit = 1'b0;
    grant_idx = 3'd0;
    scan_idx  = 3'd0;
    scan_sum  = 4'd0;
    for (int k = 0; k < 8; k++) begin
      data_arr[k] = '0;
    end
    for (int k = 0; k < NREQ; k++) begin
      data_arr[k] = req_data[k*DW +: DW];
    end
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + 4'(k);
      scan_idx = (scan_sum >= 4'(NREQ)) ? 3'(scan_sum - 4'(NREQ)) : scan_sum[2:0];
      if (!grant_hit && req8[scan_idx]) begin
        grant_hit = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      call_valid_q <= 1'b0;
      call_id_q    <= 3'd0;
      call_data_q  <= '0;
      req_ack_q    <= '0;
      cnt_q        <= 16'd0;
      run_done_q   <= 1'b0;
      rr_ptr_q     <= 3'd0;
    end else begin
      cnt_q     <= cnt_d;
      req_ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (!closed_q && grant_hit) begin
            state_q      <= CALL;
            call_valid_q <= 1'b1;
            call_id_q    <= grant_idx;
            call_data_q  <= data_arr[grant_idx];
          end else if (closed_d) begin
            state_q    <= DONE;
            run_done_q <= 1'b1;
          end
        end
        CALL: begin
          // Closing never aborts an accepted grant; it only redirects the exit.
          if (call_ready) begin
            req_ack_q    <= ack8[NREQ-1:0];
            call_valid_q <= 1'b0;
            rr_ptr_q     <= rr_next;
            if (closed_d) begin
              state_q    <= DONE;
              run_done_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DONE: begin
          call_valid_q <= 1'b0;
          run_done_q   <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          call_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack    = req_ack_q;
  assign call_valid = call_valid_q;
  assign call_id    = call_id_q;
  assign call_data  = call_data_q;
  assign cycle_cnt  = cnt_q;
  assign run_done   = run_done_q;
  assign state_dbg  = state_q;

endmodule
